// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and pixel type.
package vga_pkg;

  // 640x480@60 Hz horizontal timing, in pixel ticks
  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned H_FRONT    = 16;
  localparam int unsigned H_SYNC_LEN = 96;
  localparam int unsigned H_BACK     = 48;
  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC_LEN + H_BACK;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_LEN - 1;

  // Vertical timing, in lines
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned V_FRONT    = 10;
  localparam int unsigned V_SYNC_LEN = 2;
  localparam int unsigned V_BACK     = 33;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC_LEN + V_BACK;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_LEN - 1;

  // Framebuffer geometry: each stored pixel covers a 4x4 block on screen
  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned FB_WIDTH   = H_VISIBLE >> SCALE_LOG2;
  localparam int unsigned FB_HEIGHT  = V_VISIBLE >> SCALE_LOG2;
  localparam int unsigned FB_DEPTH   = FB_WIDTH * FB_HEIGHT;

  // Datapath widths
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned PIX_W     = 3;
  localparam int unsigned RGB_W     = 2 * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;  // {b,g,r}

  // Framebuffer address of a screen position: y*160 + x using shifts only
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h_cnt,
                                                   input logic [CNT_W-1:0] v_cnt);
    logic [FB_ADDR_W-1:0] x;
    logic [FB_ADDR_W-1:0] y;
    x = FB_ADDR_W'(h_cnt >> SCALE_LOG2);
    y = FB_ADDR_W'(v_cnt >> SCALE_LOG2);
    return (y << 7) + (y << 5) + x;
  endfunction

endpackage

// File: rtl/vga_framebuffer.sv
// 19200x3 simple dual-port RAM: port A writes, port B reads read-first.
module vga_framebuffer
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [FB_ADDR_W-1:0] wr_addr_i,
  input  pixel_t               wr_data_i,
  input  logic                 rd_en_i,
  input  logic [FB_ADDR_W-1:0] rd_addr_i,
  output pixel_t               rd_data_o
);

  pixel_t mem_q [FB_DEPTH];
  pixel_t rd_data_q;

  // Port A: out-of-range addresses are dropped rather than aliased
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_addr_i < FB_ADDR_W'(FB_DEPTH))) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Port B: registered read; a same-cycle write to this address is seen next time
  always_ff @(posedge clk) begin
    if (rd_en_i && (rd_addr_i < FB_ADDR_W'(FB_DEPTH))) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scanout with 4x4 pixel upscaling.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE_P = H_VISIBLE,
  parameter int unsigned H_FRONT_P   = H_FRONT,
  parameter int unsigned H_SYNC_P    = H_SYNC_LEN,
  parameter int unsigned H_BACK_P    = H_BACK,
  parameter int unsigned V_VISIBLE_P = V_VISIBLE,
  parameter int unsigned V_FRONT_P   = V_FRONT,
  parameter int unsigned V_SYNC_P    = V_SYNC_LEN,
  parameter int unsigned V_BACK_P    = V_BACK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FB_ADDR_W-1:0] data_addr,
  input  pixel_t               data_in,
  input  logic                 write_enable,
  output logic [RGB_W-1:0]     rgbrgb,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 vblank,
  output logic                 frame_start
);

  localparam int unsigned H_LAST   = H_VISIBLE_P + H_FRONT_P + H_SYNC_P + H_BACK_P - 1;
  localparam int unsigned V_LAST   = V_VISIBLE_P + V_FRONT_P + V_SYNC_P + V_BACK_P - 1;
  localparam int unsigned HS_FIRST = H_VISIBLE_P + H_FRONT_P;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC_P - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE_P + V_FRONT_P;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC_P - 1;

  // Pixel-tick phase and S0 counters
  logic             pix_en_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // S0 decode
  logic                 hs_c, vs_c, act_c, vb_c, first_c;
  logic                 fb_rd_en_c;
  logic [FB_ADDR_W-1:0] fb_rd_addr_c;

  // S1 delay stage (travels alongside the RAM read)
  logic   hs1_q, vs1_q, act1_q, vb1_q, first1_q;
  pixel_t fb_rd_data;

  // S2 output registers
  logic [RGB_W-1:0] rgbrgb_q;
  logic             h_sync_q, v_sync_q, vblank_q, frame_start_q;

  // Next counter values: h wraps at line end, v steps on the h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_LAST)) begin
      h_cnt_d = '0;
      if (v_cnt_q == CNT_W'(V_LAST)) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sync, blanking and read address decoded from the current counters
  always_comb begin
    hs_c         = !((h_cnt_q >= CNT_W'(HS_FIRST)) && (h_cnt_q <= CNT_W'(HS_LAST)));
    vs_c         = !((v_cnt_q >= CNT_W'(VS_FIRST)) && (v_cnt_q <= CNT_W'(VS_LAST)));
    act_c        = (h_cnt_q < CNT_W'(H_VISIBLE_P)) && (v_cnt_q < CNT_W'(V_VISIBLE_P));
    vb_c         = (v_cnt_q >= CNT_W'(V_VISIBLE_P));
    first_c      = (h_cnt_q == '0) && (v_cnt_q == '0);
    fb_rd_addr_c = fb_addr(h_cnt_q, v_cnt_q);
    fb_rd_en_c   = pix_en_q && act_c;
  end

  // Pixel-tick divider and S0 counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= !pix_en_q;
      if (pix_en_q) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
      end
    end
  end

  // S1: delay the decoded timing by one tick to meet the RAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      act1_q   <= 1'b0;
      vb1_q    <= 1'b0;
      first1_q <= 1'b0;
    end else if (pix_en_q) begin
      hs1_q    <= hs_c;
      vs1_q    <= vs_c;
      act1_q   <= act_c;
      vb1_q    <= vb_c;
      first1_q <= first_c;
    end
  end

  // S2: output registers; frame_start is held for a single clk only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgbrgb_q      <= '0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (pix_en_q) begin
        rgbrgb_q      <= act1_q ? {fb_rd_data, fb_rd_data} : '0;
        h_sync_q      <= hs1_q;
        v_sync_q      <= vs1_q;
        vblank_q      <= vb1_q;
        frame_start_q <= first1_q;
      end
    end
  end

  vga_framebuffer u_fb (
    .clk       (clk),
    .wr_en_i   (write_enable),
    .wr_addr_i (data_addr),
    .wr_data_i (data_in),
    .rd_en_i   (fb_rd_en_c),
    .rd_addr_i (fb_rd_addr_c),
    .rd_data_o (fb_rd_data)
  );

  assign rgbrgb      = rgbrgb_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shortened raster, against a position-based reference model.
module tb_vga_scanout;

  localparam int unsigned HV = 32, HF = 4, HSL = 8, HB = 4;
  localparam int unsigned VV = 16, VF = 2, VSL = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HSL + HB;   // 48 ticks per line
  localparam int unsigned VT = VV + VF + VSL + VB;   // 23 lines per frame
  localparam int unsigned FRAME = HT * VT;           // ticks per frame
  localparam int unsigned DEPTH = 19200;

  logic        clk;
  logic        rst_n;
  logic [14:0] data_addr;
  logic [2:0]  data_in;
  logic        write_enable;
  logic [5:0]  rgbrgb;
  logic        h_sync, v_sync, vblank, frame_start;

  vga_scanout #(
    .H_VISIBLE_P(HV), .H_FRONT_P(HF), .H_SYNC_P(HSL), .H_BACK_P(HB),
    .V_VISIBLE_P(VV), .V_FRONT_P(VF), .V_SYNC_P(VSL), .V_BACK_P(VB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_addr    (data_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .rgbrgb       (rgbrgb),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .vblank       (vblank),
    .frame_start  (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [2:0]  fbm [DEPTH];
  logic        m_pe;
  int unsigned m_t;      // pixel ticks elapsed since reset release
  logic [2:0]  m_rd;     // pixel fetched for the previous tick's position
  logic [5:0]  exp_rgb;
  logic        exp_hs, exp_vs, exp_vb, exp_fs;

  function automatic int unsigned hpos(input int unsigned p);
    return (p % FRAME) % HT;
  endfunction
  function automatic int unsigned vpos(input int unsigned p);
    return (p % FRAME) / HT;
  endfunction
  function automatic int unsigned ref_addr(input int unsigned p);
    return (vpos(p) / 4) * 160 + hpos(p) / 4;
  endfunction

  // Memory contents: every in-range write lands, reset or not
  always @(posedge clk) begin
    if (write_enable && (int'(data_addr) < DEPTH)) fbm[data_addr] <= data_in;
  end

  // Screen position p is fetched one tick after it is counted and shown one tick later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pe <= 1'b0; m_t <= 0; m_rd <= 3'b000;
      exp_rgb <= 6'b0; exp_hs <= 1'b1; exp_vs <= 1'b1; exp_vb <= 1'b0; exp_fs <= 1'b0;
    end else begin
      m_pe   <= ~m_pe;
      exp_fs <= 1'b0;
      if (m_pe) begin
        m_t  <= m_t + 1;
        m_rd <= (ref_addr(m_t) < DEPTH) ? fbm[ref_addr(m_t)] : 3'b000;
        if (m_t >= 1) begin
          exp_rgb <= (hpos(m_t - 1) < HV && vpos(m_t - 1) < VV) ? {m_rd, m_rd} : 6'b0;
          exp_hs  <= !(hpos(m_t - 1) >= HV + HF && hpos(m_t - 1) < HV + HF + HSL);
          exp_vs  <= !(vpos(m_t - 1) >= VV + VF && vpos(m_t - 1) < VV + VF + VSL);
          exp_vb  <= (vpos(m_t - 1) >= VV);
          exp_fs  <= ((m_t - 1) % FRAME == 0);
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int unsigned n_checks, n_pass, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("rgbrgb", 32'(rgbrgb), 32'(exp_rgb));
    chk("h_sync", 32'(h_sync), 32'(exp_hs));
    chk("v_sync", 32'(v_sync), 32'(exp_vs));
    chk("vblank", 32'(vblank), 32'(exp_vb));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic wait_fs(input string tag, input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      check_all();
      cnt++;
    end while (frame_start !== 1'b1 && cnt < budget);
    if (frame_start !== 1'b1) begin
      chk(tag, 32'(frame_start), 32'd1);
      cnt = -1;
    end
  endtask

  task automatic wait_level(input string tag, input int sel, input logic lvl,
                            input int budget, output int cnt);
    logic s;
    cnt = 0;
    do begin
      @(negedge clk);
      check_all();
      cnt++;
      s = (sel == 0) ? h_sync : v_sync;
    end while (s !== lvl && cnt < budget);
    if (s !== lvl) begin
      chk(tag, 32'(s), 32'(lvl));
      cnt = -1;
    end
  endtask

  // Wait until the next tick edge will read screen position p
  task automatic wait_pos(input string tag, input int unsigned p);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      check_all();
      cnt++;
    end while (!(m_pe && (m_t % FRAME) == p) && cnt < 4 * int'(FRAME));
    if (!(m_pe && (m_t % FRAME) == p)) chk(tag, m_t % FRAME, p);
  endtask

  task automatic write_px(input int unsigned a, input logic [2:0] d);
    @(negedge clk);
    check_all();
    write_enable = 1'b1;
    data_addr    = 15'(a);
    data_in      = d;
  endtask

  // ---------------- directed sequence ----------------
  int         cnt, off;
  logic [2:0] old_px, new_px;

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    write_enable = 1'b0; data_addr = '0; data_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rgbrgb", 32'(rgbrgb), 32'd0);
    chk("rst_h_sync", 32'(h_sync), 32'd1);
    chk("rst_v_sync", 32'(v_sync), 32'd1);
    chk("rst_vblank", 32'(vblank), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);

    // Fill the whole framebuffer with random pixels while held in reset
    for (int i = 0; i < int'(DEPTH); i++) write_px(i, 3'($urandom));
    write_px(0, 3'b001);
    write_px(161, 3'b110);
    write_px(162, 3'b011);
    write_px(DEPTH - 1, 3'b111);
    write_px(DEPTH, 3'b010);
    write_px(32767, 3'b101);
    @(negedge clk);
    check_all();
    write_enable = 1'b0;

    // Release; first frame_start two pixel ticks after the first pix_en
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs("first_fs_timeout", 20, cnt);
    chk("first_fs_latency", 32'(cnt), 32'd4);

    // Directed pixels of the first frame (offset in clk = 2 * screen position)
    chk("px_h0v0", 32'(rgbrgb), 32'h09);
    advance(6);    off = 6;    chk("px_h3v0", 32'(rgbrgb), 32'h09);
    advance(58);   off = 64;   chk("blank_h32", 32'(rgbrgb), 32'd0);
    advance(230);  off = 294;  chk("px_h3v3", 32'(rgbrgb), 32'h09);
    advance(98);   off = 392;  chk("px_h4v4", 32'(rgbrgb), 32'h36);
    advance(294);  off = 686;  chk("px_h7v7", 32'(rgbrgb), 32'h36);
    advance(850);  off = 1536; chk("vblank_v16", 32'(vblank), 32'd1);
    chk("rgb_vblank", 32'(rgbrgb), 32'd0);
    wait_fs("fs2_timeout", 2 * int'(FRAME), cnt);
    chk("frame_period_clk", 32'(off + cnt), 32'(2 * FRAME));

    // Sync pulse placement and width
    wait_level("hs_fall_timeout", 0, 1'b0, 400, cnt);
    chk("hs_fall_clk", 32'(cnt), 32'(2 * (HV + HF)));
    wait_level("hs_rise_timeout", 0, 1'b1, 400, cnt);
    chk("hs_low_clk", 32'(cnt), 32'(2 * HSL));
    wait_fs("fs3_timeout", 2 * int'(FRAME), cnt);
    wait_level("vs_fall_timeout", 1, 1'b0, 3000, cnt);
    chk("vs_fall_clk", 32'(cnt), 32'(2 * (VV + VF) * HT));
    wait_level("vs_rise_timeout", 1, 1'b1, 3000, cnt);
    chk("vs_low_clk", 32'(cnt), 32'(2 * VSL * HT));

    // Random writes while scanning: mostly visible, some out of range
    repeat (2 * 2 * FRAME) begin
      @(negedge clk);
      check_all();
      write_enable = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    data_addr = 15'($urandom_range(0, 3) * 160 + $urandom_range(0, 7));
        2:       data_addr = 15'($urandom_range(0, DEPTH - 1));
        default: data_addr = 15'($urandom_range(DEPTH, 32767));
      endcase
      data_in = 3'($urandom);
    end
    @(negedge clk);
    check_all();
    write_enable = 1'b0;

    // Same-clk write to the address being read: old now, new next frame
    wait_pos("collide_pos_timeout", 4 * HT + 8);
    old_px = fbm[162];
    new_px = ~old_px;
    write_enable = 1'b1; data_addr = 15'd162; data_in = new_px;
    @(negedge clk);
    check_all();
    write_enable = 1'b0;
    advance(2);
    chk("collide_old", 32'(rgbrgb), 32'({old_px, old_px}));
    advance(2 * FRAME);
    chk("collide_new", 32'(rgbrgb), 32'({new_px, new_px}));

    // Full framebuffer sweep
    chk("fb_19199", 32'(dut.u_fb.mem_q[DEPTH - 1]), 32'd7);
    for (int i = 0; i < int'(DEPTH); i++) chk("fb_sweep", 32'(dut.u_fb.mem_q[i]), 32'(fbm[i]));

    // Asynchronous reset mid-frame at v=10, h=20
    wait_pos("rst_pos_timeout", 10 * HT + 20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgbrgb", 32'(rgbrgb), 32'd0);
    chk("async_rst_h_sync", 32'(h_sync), 32'd1);
    chk("async_rst_v_sync", 32'(v_sync), 32'd1);
    chk("async_rst_vblank", 32'(vblank), 32'd0);
    chk("async_rst_frame_start", 32'(frame_start), 32'd0);
    advance(4);
    rst_n = 1'b1;
    wait_fs("rerun_fs_timeout", 20, cnt);
    chk("rerun_fs_latency", 32'(cnt), 32'd4);
    advance(2 * FRAME + 10);
    for (int i = 0; i < int'(DEPTH); i++) chk("fb_keep", 32'(dut.u_fb.mem_q[i]), 32'(fbm[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
